// File: rtl/stream_align.sv
// stream_align: re-aligns an early sample stream (A) with a late sample stream (B).
// A samples are held in a circular store; every B sample pops the oldest stored A
// sample and both leave together as one registered pair. When the store is empty
// and both arrive in the same cycle, the pair bypasses the store.
module stream_align #(
    parameter int W     = 16,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_b,
    input  logic          a_valid,
    input  logic [W-1:0]  a_data,
    input  logic          b_valid,
    input  logic [W-1:0]  b_data,
    input  logic          clr_err,
    output logic          out_valid,
    output logic [W-1:0]  out_a,
    output logic [W-1:0]  out_b,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    output logic          underflow
);

    // Sample store: data only, never reset
    logic [W-1:0] mem [DEPTH];

    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   level_q, level_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_a_q, out_a_d;
    logic [W-1:0]  out_b_q, out_b_d;

    logic bypass;
    logic pop;
    logic push;
    logic ovf_evt;
    logic unf_evt;

    // Decide this cycle's push/pop/bypass and compute next state of every flop
    always_comb begin
        // Both-valid on an empty store goes straight through without touching it
        bypass  = a_valid && b_valid && empty_q;
        pop     = b_valid && !empty_q;
        // When full, a simultaneous pop frees the slot the push needs
        push    = a_valid && !bypass && (!full_q || pop);
        ovf_evt = a_valid && !b_valid && full_q;
        unf_evt = b_valid && !a_valid && empty_q;

        wp_d    = push ? wp_q + AW'(1) : wp_q;
        rp_d    = pop  ? rp_q + AW'(1) : rp_q;
        level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
        full_d  = (level_d == (AW+1)'(DEPTH));
        empty_d = (level_d == '0);

        // A new event in the same cycle as a clear keeps the flag set
        overflow_d  = (overflow_q  && !clr_err) || ovf_evt;
        underflow_d = (underflow_q && !clr_err) || unf_evt;

        out_valid_d = pop || bypass;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        if (bypass) begin
            out_a_d = a_data;
            out_b_d = b_data;
        end else if (pop) begin
            out_a_d = mem[rp_q];
            out_b_d = b_data;
        end
    end

    // Store write; the old entry at rp is read before this edge overwrites it
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp_q] <= a_data;
        end
    end

    // Control, status and output registers with asynchronous reset
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wp_q        <= '0;
            rp_q        <= '0;
            level_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            level_q     <= level_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign level     = level_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_stream_align.sv
// Bench for stream_align: directed stimulus, expected pairs queued by a small
// reference model and consumed by an independent output monitor.
module tb_stream_align;

    localparam int W     = 16;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          reset_b = 1'b0;
    logic          a_valid = 1'b0;
    logic [W-1:0]  a_data = '0;
    logic          b_valid = 1'b0;
    logic [W-1:0]  b_data = '0;
    logic          clr_err = 1'b0;
    logic          out_valid;
    logic [W-1:0]  out_a;
    logic [W-1:0]  out_b;
    logic [AW:0]   level;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          underflow;

    stream_align #(.W(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_b   (reset_b),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .clr_err   (clr_err),
        .out_valid (out_valid),
        .out_a     (out_a),
        .out_b     (out_b),
        .level     (level),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    int nchecks = 0;
    int nerrs   = 0;

    // Scoreboard of expected pairs {a, b} and the reference store of A samples
    logic [2*W-1:0] exp_q [$];
    logic [W-1:0]   aq [$];
    logic           m_ovf = 1'b0;
    logic           m_unf = 1'b0;
    logic           m_ov  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        nchecks++;
        if (act !== expv) begin
            nerrs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Output monitor: every presented pair must be the oldest expected one
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                nchecks++;
                if (exp_q.size() == 0) begin
                    nerrs++;
                    $display("FAIL unexpected_pair: got a=0x%0h b=0x%0h expected none", out_a, out_b);
                end else begin
                    logic [2*W-1:0] e;
                    e = exp_q.pop_front();
                    if ({out_a, out_b} !== e) begin
                        nerrs++;
                        $display("FAIL pair: got a=0x%0h b=0x%0h expected a=0x%0h b=0x%0h",
                                 out_a, out_b, e[2*W-1:W], e[W-1:0]);
                    end
                end
            end
        end
    end

    // One clock of stimulus; model advances at the edge, status checked at negedge
    task automatic cyc(input logic av, input logic [W-1:0] a, input logic bv,
                       input logic [W-1:0] b, input logic clr);
        logic oe, ue;
        a_valid = av; a_data = a; b_valid = bv; b_data = b; clr_err = clr;
        @(posedge clk);
        oe = 1'b0; ue = 1'b0; m_ov = 1'b0;
        if (bv) begin
            if (aq.size() > 0) begin
                exp_q.push_back({aq.pop_front(), b});
                m_ov = 1'b1;
                if (av) aq.push_back(a);
            end else if (av) begin
                exp_q.push_back({a, b});
                m_ov = 1'b1;
            end else begin
                ue = 1'b1;
            end
        end else if (av) begin
            if (aq.size() < DEPTH) aq.push_back(a);
            else oe = 1'b1;
        end
        m_ovf = (m_ovf && !clr) || oe;
        m_unf = (m_unf && !clr) || ue;
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0; clr_err = 1'b0;
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("level", 32'(level), 32'(aq.size()));
        chk("full", 32'(full), 32'(aq.size() == DEPTH));
        chk("empty", 32'(empty), 32'(aq.size() == 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_a"}, 32'(out_a), 32'd0);
        chk({tag, "_out_b"}, 32'(out_b), 32'd0);
        chk({tag, "_level"}, 32'(level), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
        chk({tag, "_underflow"}, 32'(underflow), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk_reset_state("reset");
        reset_b = 1'b1;
        @(negedge clk);

        // Constant skew of 3: A 0x0001..0x0010, B 0x1001..0x1010
        for (int i = 0; i < 19; i++) begin
            cyc(i < 16, W'(i + 1), i >= 3, W'(16'h1000 + i - 2), 1'b0);
            if (i >= 2 && i < 16) chk("skew_level3", 32'(level), 32'd3);
        end

        // Bypass from empty
        cyc(1'b1, 16'h00AA, 1'b1, 16'h00BB, 1'b0);
        chk("bypass_a", 32'(out_a), 32'h00AA);
        chk("bypass_b", 32'(out_b), 32'h00BB);
        chk("bypass_level", 32'(level), 32'd0);

        // Overflow: 17 pushes with no B
        for (int i = 0; i < 17; i++) begin
            cyc(1'b1, W'(16'h0100 + i), 1'b0, '0, 1'b0);
            if (i == 15) chk("full_after_16", 32'(full), 32'd1);
        end
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_level", 32'(level), 32'd16);
        // Push and pop together while full
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, W'(16'h0200 + i), 1'b1, W'(16'h2100 + i), 1'b0);
            chk("full_pp_level", 32'(level), 32'd16);
        end
        cyc(1'b0, '0, 1'b0, '0, 1'b1);
        chk("ovf_cleared", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) cyc(1'b0, '0, 1'b1, W'(16'h3000 + i), 1'b0);

        // Underflow, then a later pair still aligns
        cyc(1'b0, '0, 1'b1, 16'h0055, 1'b0);
        chk("unf_set", 32'(underflow), 32'd1);
        chk("unf_no_valid", 32'(out_valid), 32'd0);
        cyc(1'b1, 16'h0077, 1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b1, 16'h0088, 1'b0);
        chk("after_unf_a", 32'(out_a), 32'h0077);
        cyc(1'b0, '0, 1'b0, '0, 1'b1);

        // Wrap-around: 40 pairs at skew 5
        for (int i = 0; i < 45; i++)
            cyc(i < 40, W'(16'h4000 + i), i >= 5, W'(16'h5000 + i - 5), 1'b0);

        // Mid-operation reset with level 7
        for (int i = 0; i < 7; i++) cyc(1'b1, W'(16'h0600 + i), 1'b0, '0, 1'b0);
        chk("pre_reset_level", 32'(level), 32'd7);
        #1 reset_b = 1'b0;
        #1 chk_reset_state("midreset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_state("midreset_hold");
        aq.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        reset_b = 1'b1;
        cyc(1'b0, '0, 1'b1, 16'h0099, 1'b0);
        chk("post_reset_unf", 32'(underflow), 32'd1);

        // Drain and confirm every expected pair appeared
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end

endmodule
